// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu - load/store unit, sole master of the data memory.
//
// Accepts one CPU load/store at a time (valid/ready), spends exactly one
// ACCESS cycle on the memory, then holds a response until it is taken.
// Stores are encoded into the memory's 4-bit lane write code with the data
// replicated across lanes. Loads extract the addressed byte/halfword from the
// little-endian read word and sign- or zero-extend it. Misaligned or
// out-of-range accesses return resp_err=1, resp_rdata=0 and never write.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_store, req_size,       request attributes (size: 00 B, 01 H, 10 W,
//   req_unsigned, req_addr,    11 reserved -> error)
//   req_wdata
//   resp_valid / resp_ready    response handshake
//   resp_rdata, resp_err       load result / error flag
//   daddr, dwdata, we, drdata  data memory port (we: 0 none, 1-4 byte lane
//                              0-3, 5 lanes 1:0, 7 lanes 3:2, 8 all lanes)
// -----------------------------------------------------------------------------
module lsu #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  we,
    input  logic [31:0] drdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic [31:0] daddr_q,      daddr_d;
    logic [31:0] dwdata_q,     dwdata_d;
    logic [1:0]  size_q,       size_d;
    logic        store_q,      store_d;
    logic        uns_q,        uns_d;
    logic        err_q,        err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;

    // Reserved size, misalignment, or address beyond the memory.
    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | (addr >= 32'(MEM_BYTES));
    endfunction

    // Replicate right-aligned store data across all lanes it may land in.
    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{wdata[7:0]}};
            2'b01:   r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Lane write code; only called for legal (aligned, non-reserved) stores.
    function automatic logic [3:0] we_code(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] c;
        case (size)
            2'b00:   c = {2'b00, ofs} + 4'd1;
            2'b01:   c = ofs[1] ? 4'd7 : 4'd5;
            2'b10:   c = 4'd8;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                 input logic [1:0] ofs, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{ofs, 3'b000} +: 8];
        h = rd[{ofs[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   r = rd;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Next-state and datapath capture logic.
    always_comb begin
        state_d      = state_q;
        daddr_d      = daddr_q;
        dwdata_d     = dwdata_q;
        size_d       = size_q;
        store_d      = store_q;
        uns_d        = uns_q;
        err_d        = err_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    daddr_d  = req_addr;
                    dwdata_d = lane_rep(req_size, req_wdata);
                    size_d   = req_size;
                    store_d  = req_store;
                    uns_d    = req_unsigned;
                    err_d    = access_err(req_size, req_addr);
                    state_d  = ST_ACCESS;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // drdata is combinational from daddr, so it is valid here.
                if (!store_q && !err_q) begin
                    resp_rdata_d = load_extract(size_q, uns_q, daddr_q[1:0], drdata);
                end else begin
                    resp_rdata_d = 32'h0000_0000;
                end
                resp_err_d = err_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            daddr_q      <= 32'h0000_0000;
            dwdata_q     <= 32'h0000_0000;
            size_q       <= 2'b00;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            daddr_q      <= daddr_d;
            dwdata_q     <= dwdata_d;
            size_q       <= size_d;
            store_q      <= store_d;
            uns_q        <= uns_d;
            err_q        <= err_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Write strobe decoded from state so an asserted reset kills it at once.
    always_comb begin
        if ((state_q == ST_ACCESS) && store_q && !err_q) begin
            we = we_code(size_q, daddr_q[1:0]);
        end else begin
            we = 4'd0;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign daddr      = daddr_q;
    assign dwdata     = dwdata_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu - directed table-driven bench for lsu, with a behavioural 128-byte
// data memory, plus hand-written backpressure and mid-access reset sequences.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:31];

    always #5 clk = ~clk;

    lsu #(.MEM_BYTES(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .daddr(daddr),
        .dwdata(dwdata), .we(we), .drdata(drdata)
    );

    // Data memory: combinational read, lane writes on the rising edge.
    assign drdata = mem[daddr[6:2]];

    always @(posedge clk) begin
        case (we)
            4'd1: mem[daddr[6:2]][7:0]   <= dwdata[7:0];
            4'd2: mem[daddr[6:2]][15:8]  <= dwdata[15:8];
            4'd3: mem[daddr[6:2]][23:16] <= dwdata[23:16];
            4'd4: mem[daddr[6:2]][31:24] <= dwdata[31:24];
            4'd5: mem[daddr[6:2]][15:0]  <= dwdata[15:0];
            4'd7: mem[daddr[6:2]][31:16] <= dwdata[31:16];
            4'd8: mem[daddr[6:2]]        <= dwdata;
            default: ;
        endcase
    end

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic        chk_dw;
        logic [31:0] exp_dw;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [0:NV-1];

    function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] ewe, input logic cdw, input logic [31:0] edw,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.store = st; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_we = ewe; v.chk_dw = cdw; v.exp_dw = edw;
        v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One full transaction with fixed 3-cycle timing and resp_ready=1 in RESP.
    task automatic do_op(input string nm, input vec_t v);
        @(negedge clk);
        chk({nm, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = v.store; req_size = v.size;
        req_unsigned = v.uns; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({nm, ".we"}, {28'd0, we}, {28'd0, v.exp_we});
        chk({nm, ".daddr"}, daddr, v.addr);
        if (v.chk_dw) chk({nm, ".dwdata"}, dwdata, v.exp_dw);
        chk({nm, ".ready_access"}, {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({nm, ".rdata"}, resp_rdata, v.exp_rdata);
        chk({nm, ".err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
        chk({nm, ".we_resp"}, {28'd0, we}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0000;
        mem[0]  = 32'h0102_0304;
        mem[4]  = 32'h8899_AABB;
        mem[31] = 32'h7654_3210;

        //         st    sz     u     addr          wdata         we     cdw   dw             rdata          err
        vt[0]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'hFFFF_FFAA, 1'b0);
        vt[1]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h0000_00AA, 1'b0);
        vt[2]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'hFFFF_8899, 1'b0);
        vt[3]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h0000_AABB, 1'b0);
        vt[4]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 4'd4, 1'b1, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
        vt[5]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'hA599_AABB, 1'b0);
        vt[6]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h0000_1234, 4'd7, 1'b1, 32'h1234_1234, 32'h0000_0000, 1'b0);
        vt[7]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h1234_0000, 1'b0);
        vt[8]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'hDEAD_BEEF, 4'd8, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        vt[9]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        vt[10] = mk(1'b1, 2'b00, 1'b0, 32'h0000_0002, 32'h0000_005A, 4'd3, 1'b1, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0);
        vt[11] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0002, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h0000_005A, 1'b0);
        vt[12] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0008, 32'h0000_BEEF, 4'd5, 1'b1, 32'hBEEF_BEEF, 32'h0000_0000, 1'b0);
        vt[13] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h0000_BEEF, 1'b0);
        // Rejected accesses: no write, zero data, error flag.
        vt[14] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        vt[15] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0015, 32'h0000_FFFF, 4'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        vt[16] = mk(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1122_3344, 4'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1);
        vt[17] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'hCAFE_BABE, 4'd0, 1'b1, 32'hCAFE_BABE, 32'h0000_0000, 1'b1);
        // Memory untouched by the rejected stores; last legal word.
        vt[18] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'hA599_AABB, 1'b0);
        vt[19] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h1234_0000, 1'b0);
        vt[20] = mk(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h015A_0304, 1'b0);
        vt[21] = mk(1'b0, 2'b10, 1'b0, 32'h0000_007C, 32'h0000_0000, 4'd0, 1'b1, 32'h0000_0000, 32'h7654_3210, 1'b0);

        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err", {31'd0, resp_err}, 32'd0);
        chk("rst.daddr", daddr, 32'd0);
        chk("rst.dwdata", dwdata, 32'd0);
        chk("rst.we", {28'd0, we}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) do_op($sformatf("v%0d", i), vt[i]);

        // Backpressure: hold response 4 cycles while a new request waits.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h0000_0010;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.resp_valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp%0d.rdata", i), resp_rdata, 32'hA599_AABB);
            chk($sformatf("bp%0d.req_ready", i), {31'd0, req_ready}, 32'd0);
            chk($sformatf("bp%0d.we", i), {28'd0, we}, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp.idle_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp.next_access", {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.next_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp.next_rdata", resp_rdata, 32'h0000_00BB);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset during ACCESS of a word store: write aborted.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10;
        req_addr = 32'h0000_0010; req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rs.we_before", {28'd0, we}, 32'd8);
        #1 rst_n = 1'b0;
        #1;
        chk("rs.we", {28'd0, we}, 32'd0);
        chk("rs.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rs.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rs.rdata", resp_rdata, 32'd0);
        chk("rs.err", {31'd0, resp_err}, 32'd0);
        chk("rs.daddr", daddr, 32'd0);
        chk("rs.dwdata", dwdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rs.no_resp", {31'd0, resp_valid}, 32'd0);
        do_op("rs.after", vt[18]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
